maxpool_2x2: RTL
================

// Module: maxpool_2x2
// PURPOSE
//  2x2 stride-2 max-pooling stage directly downstream of in-place ReLU.
//  - Reads the activated CONV buffer BRAM (CHW, raster order) and writes each pooled value to a separate POOL buffer BRAM.
//  - Started by the top-level sequencer once ReLU reports done; its done starts the next stage (flatten/dense).
// PARAMETERS
//  DATA_WIDTH  16  signed sample width (two's complement)
//  CHANNELS     8  feature-map channels
//  IMG_SIZE    28  input height = width; OUT = IMG_SIZE/2 (floor)
// PORTS
//  clk          in   1    clock, all logic on rising edge
//  reset_n      in   1    synchronous reset, active-low
//  start        in   1    1-cycle pulse; sampled only in IDLE
//  conv_r_addr  out  CAW  CONV BRAM read addr; CAW=$clog2(CHANNELS*IMG_SIZE^2)
//  conv_r_en    out  1    CONV BRAM read enable
//  conv_r_q     in   DW   CONV BRAM read data, valid 1 cycle after conv_r_en
//  pool_w_addr  out  PAW  POOL BRAM write addr; PAW=$clog2(CHANNELS*OUT^2)
//  pool_w_en    out  1    POOL BRAM enable
//  pool_w_we    out  1    POOL BRAM write enable (always equal to pool_w_en)
//  pool_w_d     out  DW   pooled value
//  busy         out  1    high from cycle after start accepted until done
//  done         out  1    1-cycle completion pulse
// BEHAVIOUR
//  - Reset (reset_n=0): state IDLE, counters 0. All enables, busy and done = 0. Addresses and data = 0.
//  - FSM: IDLE -> RD (4 cycles, k=0..3) -> LAST -> WR -> (next window: RD | all done: FINISH) -> IDLE.
//  - Window (ch,pr,pc), k order (dy,dx) = (0,0),(0,1),(1,0),(1,1):
//      conv addr = (ch*IMG_SIZE + 2*pr+dy)*IMG_SIZE + 2*pc+dx
//  - RD issues one read per cycle. Data for read k-1 is captured in RD k>=1; data for read 3 in LAST.
//  - First sample loads max; later samples replace it if strictly greater (signed compare, ties keep earlier).
//  - WR: single write, pool addr = (ch*OUT + pr)*OUT + pc; conv_r_en = 0 in LAST/WR.
//  - Order/timing: pc fastest, then pr, then ch. Exactly 6 cycles per window.
//      - pool_w_en pulses every 6 cycles.
//      - First conv_r_en: cycle after start is sampled.
//  - done: high exactly 1 cycle, the cycle after the final pool_w_en; busy drops in the same cycle.
//  - Total writes: NWIN = CHANNELS*OUT*OUT (1568 at defaults); no address is written twice.
//  - Odd IMG_SIZE: last row and last column are never read.
//  - start while busy: ignored (no restart, no queueing).
//  - start and reset_n=0 in the same cycle: reset wins.
//  - reset_n low mid-run: outputs return to reset values next cycle; no done; next start runs a full pass.
//  - Counter wrap: ch/pr/pc wrap to 0 after the last window, so a second start repeats identically.
// CONFIGURATION
//  - MAXPOOL_FUSED_RELU_EN defined: pool_w_d = max<0 ? 0 : max, so the ReLU pass can be skipped.
//  - Undefined: pool_w_d = raw signed max; negatives pass through.
//  - Timing and addressing are identical either way.
// STRUCTURE
//  - cnn_pkg:
//      - types: data_t (signed DATA_WIDTH), pool_st_t enum {IDLE,RD,LAST,WR,FINISH}
//      - functions: lin3(ch,row,col,h,w), clog2-based address-width helpers
//  - Sub-module pool_win_cnt: nested ch/pr/pc counters with k index; produces last_k, last_win, conv and pool addrs.
//  - Top holds the FSM, max register and BRAM strobes.
// TESTING
//  1. CH=1,IMG=4, conv = 0..15 raster -> pool[0..3] = 5,7,13,15; 4 writes; done once.
//  2. CH=1,IMG=2, window {-3,-1,-7,-2}:
//     - macro undefined -> pool[0] = -1 (0xFFFF)
//     - macro defined   -> pool[0] = 0
//  3. Defaults with random signed data -> all 1568 writes match golden model, in order; write spacing 6 cycles; done 1 cycle.
//  4. Extra start pulses at cycles 10 and 500 of a run -> ignored; write count and done timing unchanged.
//  5. reset_n=0 at cycle 300 -> enables, busy, done = 0 next cycle.
//     - Then start -> full pass from addr 0, results correct.
//  6. CH=2,IMG=5 -> 8 writes; conv rows/cols 4 never addressed; pool[4..7] = ch1 maxima.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and address helpers for the CNN pooling datapath.
package cnn_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_CHANNELS   = 8;
   localparam int DEF_IMG_SIZE   = 28;

   typedef logic signed [DEF_DATA_WIDTH-1:0] data_t;

   typedef enum logic [2:0] {IDLE, RD, LAST, WR, FINISH} pool_st_t;

   // Never return zero, so a single-entry buffer still gets a 1-bit address.
   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int conv_aw(input int ch, input int img);
      return addr_w(ch * img * img);
   endfunction

   function automatic int pool_aw(input int ch, input int img);
      return addr_w(ch * (img / 2) * (img / 2));
   endfunction

   function automatic int lin3(input int ch, input int row, input int col,
                               input int h, input int w);
      return (ch * h + row) * w + col;
   endfunction

endpackage

// File: rtl/maxpool_2x2_win_cnt.sv
// Window walker for the 2x2 pool: k (tap) inside pc, pr, ch; derives the
// CONV read address of the current tap and the POOL address of the window.
module pool_win_cnt
   import cnn_pkg::*;
#(
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int IMG_SIZE = DEF_IMG_SIZE,
   localparam int OUT = IMG_SIZE / 2,
   localparam int CAW = conv_aw(CHANNELS, IMG_SIZE),
   localparam int PAW = pool_aw(CHANNELS, IMG_SIZE),
   localparam int CHW = addr_w(CHANNELS),
   localparam int OW  = addr_w(OUT)
)(
   input  logic           clk,
   input  logic           reset_n,
   input  logic           i_inc_k,
   input  logic           i_inc_win,
   output logic [1:0]     o_k,
   output logic           o_last_k,
   output logic           o_last_win,
   output logic [CAW-1:0] o_conv_addr,
   output logic [PAW-1:0] o_pool_addr
);

   logic [1:0]     r_k;
   logic [CHW-1:0] r_ch;
   logic [OW-1:0]  r_pr;
   logic [OW-1:0]  r_pc;
   logic           w_last_pc;
   logic           w_last_pr;
   logic           w_last_ch;

   assign w_last_pc  = (int'(r_pc) == OUT - 1);
   assign w_last_pr  = (int'(r_pr) == OUT - 1);
   assign w_last_ch  = (int'(r_ch) == CHANNELS - 1);
   assign o_k        = r_k;
   assign o_last_k   = (r_k == 2'd3);
   assign o_last_win = w_last_pc && w_last_pr && w_last_ch;

   // k[1] selects the row offset (dy), k[0] the column offset (dx).
   assign o_conv_addr = CAW'(lin3(int'(r_ch), 2 * int'(r_pr) + int'(r_k[1]),
                                  2 * int'(r_pc) + int'(r_k[0]), IMG_SIZE, IMG_SIZE));
   assign o_pool_addr = PAW'(lin3(int'(r_ch), int'(r_pr), int'(r_pc), OUT, OUT));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_k  <= '0;
         r_ch <= '0;
         r_pr <= '0;
         r_pc <= '0;
      end else begin
         if (i_inc_k)
            r_k <= r_k + 2'd1;
         if (i_inc_win) begin
            if (!w_last_pc) begin
               r_pc <= r_pc + OW'(1);
            end else begin
               r_pc <= '0;
               if (!w_last_pr) begin
                  r_pr <= r_pr + OW'(1);
               end else begin
                  r_pr <= '0;
                  r_ch <= w_last_ch ? '0 : r_ch + CHW'(1);
               end
            end
         end
      end
   end

endmodule

// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 max-pool from the CONV buffer into the POOL buffer.
// Optional MAXPOOL_FUSED_RELU_EN clamps negative maxima to zero on write.
//
// state  | meaning
// IDLE   | waiting for start
// RD     | one CONV read per cycle, taps k=0..3; capture tap k-1
// LAST   | capture tap 3, register pooled result
// WR     | single POOL write; advance to next window
// FINISH | done pulse, busy low
module maxpool_2x2
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int CHANNELS   = DEF_CHANNELS,
   parameter int IMG_SIZE   = DEF_IMG_SIZE,
   localparam int CAW = conv_aw(CHANNELS, IMG_SIZE),
   localparam int PAW = pool_aw(CHANNELS, IMG_SIZE)
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic [CAW-1:0]        conv_r_addr,
   output logic                  conv_r_en,
   input  logic [DATA_WIDTH-1:0] conv_r_q,
   output logic [PAW-1:0]        pool_w_addr,
   output logic                  pool_w_en,
   output logic                  pool_w_we,
   output logic [DATA_WIDTH-1:0] pool_w_d,
   output logic                  busy,
   output logic                  done
);

   pool_st_t                     r_state;
   logic                         r_conv_en;
   logic                         r_pool_en;
   logic                         r_busy;
   logic                         r_done;
   logic signed [DATA_WIDTH-1:0] r_max;
   logic signed [DATA_WIDTH-1:0] r_pool_d;
   logic signed [DATA_WIDTH-1:0] w_q;
   logic signed [DATA_WIDTH-1:0] w_final;
   logic signed [DATA_WIDTH-1:0] w_out;
   logic [1:0]                   w_k;
   logic                         w_last_k;
   logic                         w_last_win;

   pool_win_cnt #(
      .CHANNELS (CHANNELS),
      .IMG_SIZE (IMG_SIZE)
   ) u_cnt (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_inc_k     (r_state == RD),
      .i_inc_win   (r_state == WR),
      .o_k         (w_k),
      .o_last_k    (w_last_k),
      .o_last_win  (w_last_win),
      .o_conv_addr (conv_r_addr),
      .o_pool_addr (pool_w_addr)
   );

   assign w_q     = signed'(conv_r_q);
   assign w_final = (w_q > r_max) ? w_q : r_max;

`ifdef MAXPOOL_FUSED_RELU_EN
   assign w_out = w_final[DATA_WIDTH-1] ? '0 : w_final;
`else
   assign w_out = w_final;
`endif

   assign conv_r_en = r_conv_en;
   assign pool_w_en = r_pool_en;
   assign pool_w_we = r_pool_en;
   assign pool_w_d  = r_pool_d;
   assign busy      = r_busy;
   assign done      = r_done;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_conv_en <= 1'b0;
         r_pool_en <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_max     <= '0;
         r_pool_d  <= '0;
      end else begin
         r_done    <= 1'b0;
         r_pool_en <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state   <= RD;
                  r_conv_en <= 1'b1;
                  r_busy    <= 1'b1;
               end
            end
            RD: begin
               // Strict compare keeps the earlier tap on ties; tap 0 always loads.
               if (w_k != 2'd0)
                  r_max <= (w_k == 2'd1 || w_q > r_max) ? w_q : r_max;
               if (w_last_k) begin
                  r_state   <= LAST;
                  r_conv_en <= 1'b0;
               end
            end
            LAST: begin
               r_pool_d  <= w_out;
               r_pool_en <= 1'b1;
               r_state   <= WR;
            end
            WR: begin
               if (w_last_win) begin
                  r_state <= FINISH;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state   <= RD;
                  r_conv_en <= 1'b1;
               end
            end
            FINISH:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
